// File: rtl/fp_pkg.sv
// Shared definitions for the FP compare/min-max path: op encoding and canonical NaN.
package fp_pkg;

  localparam int unsigned FP_OP_W   = 3;
  localparam int unsigned FP_MAX_W  = 64;

  localparam logic [FP_OP_W-1:0] OP_FEQ  = 3'd0;
  localparam logic [FP_OP_W-1:0] OP_FLT  = 3'd1;
  localparam logic [FP_OP_W-1:0] OP_FLE  = 3'd2;
  localparam logic [FP_OP_W-1:0] OP_FMIN = 3'd3;
  localparam logic [FP_OP_W-1:0] OP_FMAX = 3'd4;

  // Positive quiet NaN with only the fraction MSB set, right-aligned in FP_MAX_W bits.
  function automatic logic [FP_MAX_W-1:0] fp_cnan(int unsigned exp_w, int unsigned man_w);
    logic [FP_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < exp_w; i++) begin
      r[man_w+i] = 1'b1;
    end
    r[man_w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: NaN/sNaN/zero detection plus sign and magnitude split.
module fp_classify
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0]   val,
  output logic                   is_nan,
  output logic                   is_snan,
  output logic                   is_zero,
  output logic                   sign,
  output logic [EXP_W+MAN_W-1:0] mag
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_frac;

  assign w_exp   = val[MAN_W +: EXP_W];
  assign w_frac  = val[MAN_W-1:0];
  assign sign    = val[EXP_W+MAN_W];
  assign mag     = val[EXP_W+MAN_W-1:0];

  assign is_nan  = (&w_exp) & (|w_frac);
  assign is_snan = is_nan & ~w_frac[MAN_W-1];
  assign is_zero = ~(|w_exp) & ~(|w_frac);

endmodule

// File: rtl/fp_cmp_unit.sv
// Two-stage IEEE-754 compare / min-max unit with RISC-V NaN and invalid-flag semantics.
module fp_cmp_unit
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FP_OP_W-1:0]   in_op,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_data,
  output logic                 out_nv
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned MAG_W = EXP_W + MAN_W;
  localparam logic [W-1:0] CNAN = W'(fp_cnan(EXP_W, MAN_W));

  // Sign-magnitude ordering; -0 sorts below +0 here, callers mask zeros where needed.
  function automatic logic mag_lt(logic sa, logic [MAG_W-1:0] ma, logic sb,
                                  logic [MAG_W-1:0] mb);
    if (sa != sb) return sa;
    else if (sa)  return ma > mb;
    else          return ma < mb;
  endfunction

  logic w_en;
  logic w_a_nan, w_a_snan, w_a_zero, w_a_sign;
  logic w_b_nan, w_b_snan, w_b_zero, w_b_sign;
  logic [MAG_W-1:0] w_a_mag, w_b_mag;

  logic               r_s1_valid;
  logic [FP_OP_W-1:0] r_s1_op;
  logic [W-1:0]       r_s1_a, r_s1_b;
  logic               r_s1_a_nan, r_s1_a_snan, r_s1_a_zero, r_s1_a_sign;
  logic               r_s1_b_nan, r_s1_b_snan, r_s1_b_zero, r_s1_b_sign;
  logic [MAG_W-1:0]   r_s1_a_mag, r_s1_b_mag;

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_out_nv;

  logic         w_any_nan, w_any_snan, w_both_zero, w_same, w_lt_ab, w_lt_ba;
  logic [W-1:0] w_res;
  logic         w_nv;

  assign w_en      = ~r_out_valid | out_ready;
  assign in_ready  = w_en & ~flush;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_nv    = r_out_nv;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .val     (in_a),
    .is_nan  (w_a_nan),
    .is_snan (w_a_snan),
    .is_zero (w_a_zero),
    .sign    (w_a_sign),
    .mag     (w_a_mag)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .val     (in_b),
    .is_nan  (w_b_nan),
    .is_snan (w_b_snan),
    .is_zero (w_b_zero),
    .sign    (w_b_sign),
    .mag     (w_b_mag)
  );

  always_comb begin
    w_any_nan   = r_s1_a_nan | r_s1_b_nan;
    w_any_snan  = r_s1_a_snan | r_s1_b_snan;
    w_both_zero = r_s1_a_zero & r_s1_b_zero;
    w_same      = (r_s1_a_sign == r_s1_b_sign) && (r_s1_a_mag == r_s1_b_mag);
    w_lt_ab     = mag_lt(r_s1_a_sign, r_s1_a_mag, r_s1_b_sign, r_s1_b_mag);
    w_lt_ba     = mag_lt(r_s1_b_sign, r_s1_b_mag, r_s1_a_sign, r_s1_a_mag);
    w_res       = '0;
    w_nv        = 1'b0;
    case (r_s1_op)
      OP_FEQ: begin
        w_res[0] = ~w_any_nan & (w_both_zero | w_same);
        w_nv     = w_any_snan;
      end
      OP_FLT: begin
        w_res[0] = ~w_any_nan & ~w_both_zero & w_lt_ab;
        w_nv     = w_any_nan;
      end
      OP_FLE: begin
        w_res[0] = ~w_any_nan & (w_both_zero | w_same | w_lt_ab);
        w_nv     = w_any_nan;
      end
      OP_FMIN, OP_FMAX: begin
        w_nv = w_any_snan;
        if (r_s1_a_nan && r_s1_b_nan) w_res = CNAN;
        else if (r_s1_a_nan)          w_res = r_s1_b;
        else if (r_s1_b_nan)          w_res = r_s1_a;
        else if (r_s1_op == OP_FMIN)  w_res = w_lt_ba ? r_s1_b : r_s1_a;
        else                          w_res = w_lt_ab ? r_s1_b : r_s1_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_a_nan  <= 1'b0;
      r_s1_a_snan <= 1'b0;
      r_s1_a_zero <= 1'b0;
      r_s1_a_sign <= 1'b0;
      r_s1_a_mag  <= '0;
      r_s1_b_nan  <= 1'b0;
      r_s1_b_snan <= 1'b0;
      r_s1_b_zero <= 1'b0;
      r_s1_b_sign <= 1'b0;
      r_s1_b_mag  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_nv    <= 1'b0;
    end else begin
      if (flush) begin
        r_s1_valid  <= 1'b0;
        r_out_valid <= 1'b0;
      end else if (w_en) begin
        r_s1_valid  <= in_valid;
        r_out_valid <= r_s1_valid;
      end
      // Payload only moves when the pipe advances so a stalled result stays put.
      if (w_en) begin
        r_s1_op     <= in_op;
        r_s1_a      <= in_a;
        r_s1_b      <= in_b;
        r_s1_a_nan  <= w_a_nan;
        r_s1_a_snan <= w_a_snan;
        r_s1_a_zero <= w_a_zero;
        r_s1_a_sign <= w_a_sign;
        r_s1_a_mag  <= w_a_mag;
        r_s1_b_nan  <= w_b_nan;
        r_s1_b_snan <= w_b_snan;
        r_s1_b_zero <= w_b_zero;
        r_s1_b_sign <= w_b_sign;
        r_s1_b_mag  <= w_b_mag;
        r_out_data  <= w_res;
        r_out_nv    <= w_nv;
      end
    end
  end

endmodule

// File: tb/tb_fp_cmp_unit.sv
// Scoreboard bench for fp_cmp_unit: single-precision instance plus a double-precision one.
module tb_fp_cmp_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, flush, in_valid, in_ready, out_valid, out_ready, out_nv;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, out_data;

  logic        d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_nv;
  logic [2:0]  d_in_op;
  logic [63:0] d_in_a, d_in_b, d_out_data;

  fp_cmp_unit #(.EXP_W(8), .MAN_W(23)) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nv    (out_nv)
  );

  fp_cmp_unit #(.EXP_W(11), .MAN_W(52)) u_dut_d (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (d_flush),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_op     (d_in_op),
    .in_a      (d_in_a),
    .in_b      (d_in_b),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_data  (d_out_data),
    .out_nv    (d_out_nv)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        nv;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur_exp;
  int   n_chk = 0;
  int   n_bad = 0;
  logic tog_run;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Every cycle with a valid result it must match the oldest pending expectation.
  always @(negedge clk) begin
    if (resetn) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          check("data", 64'(out_data), 64'(sb_q[0].data));
          check("nv", 64'(out_nv), 64'(sb_q[0].nv));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ed, input logic en);
    int k;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    cur_exp  = {ed, en};
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain_left", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic dsend_chk(input string tag, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] ed, input logic en);
    d_in_valid = 1'b1;
    d_in_op    = op;
    d_in_a     = a;
    d_in_b     = b;
    check({tag, "_rdy"}, 64'(d_in_ready), 64'd1);
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(d_out_valid), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_vld"}, 64'(d_out_valid), 64'd1);
    check({tag, "_data"}, d_out_data, ed);
    check({tag, "_nv"}, 64'(d_out_nv), 64'(en));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time=%0t want finish before 200000", $time);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0; cur_exp = '0; tog_run = 1'b0;
    d_flush = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b1;
    d_in_op = '0; d_in_a = '0; d_in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_nv", 64'(out_nv), 64'd0);
    check("rst_d_valid", 64'(d_out_valid), 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: accepted at edge k, valid after edge k+1.
    send(3'd1, 32'h3F800000, 32'h40000000, 32'd1, 1'b0);
    check("lat_s1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_s2", 64'(out_valid), 64'd1);
    drain();

    send(3'd0, 32'h80000000, 32'h00000000, 32'd1, 1'b0);
    send(3'd2, 32'h80000000, 32'h00000000, 32'd1, 1'b0);
    send(3'd1, 32'h80000000, 32'h00000000, 32'd0, 1'b0);
    send(3'd0, 32'h7FC00000, 32'h3F800000, 32'd0, 1'b0);
    send(3'd0, 32'h7F800001, 32'h3F800000, 32'd0, 1'b1);
    send(3'd1, 32'h7FC00000, 32'h3F800000, 32'd0, 1'b1);
    send(3'd3, 32'h7F800001, 32'hBF800000, 32'hBF800000, 1'b1);
    send(3'd4, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0);
    send(3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0);
    send(3'd4, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
    send(3'd1, 32'hC0000000, 32'hBF800000, 32'd1, 1'b0);
    send(3'd1, 32'hBF800000, 32'hC0000000, 32'd0, 1'b0);
    send(3'd4, 32'hBF800000, 32'hC0000000, 32'hBF800000, 1'b0);
    send(3'd3, 32'h7F800000, 32'h3F800000, 32'h3F800000, 1'b0);
    send(3'd2, 32'h40000000, 32'h3F800000, 32'd0, 1'b0);
    send(3'd6, 32'h7F800001, 32'h3F800000, 32'd0, 1'b0);
    drain();

    // Back-to-back stream with a toggling consumer.
    tog_run = 1'b1;
    fork
      begin
        send(3'd1, 32'h3F800000, 32'h40000000, 32'd1, 1'b0);
        send(3'd2, 32'h40000000, 32'h40000000, 32'd1, 1'b0);
        send(3'd0, 32'h40000000, 32'h40400000, 32'd0, 1'b0);
        send(3'd4, 32'h3F800000, 32'h40400000, 32'h40400000, 1'b0);
        send(3'd3, 32'hC0400000, 32'h3F800000, 32'hC0400000, 1'b0);
        send(3'd7, 32'h3F800000, 32'h3F800000, 32'd0, 1'b0);
        send(3'd4, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1);
        send(3'd1, 32'hFF800000, 32'h00000000, 32'd1, 1'b0);
        drain();
        tog_run = 1'b0;
      end
      begin
        while (tog_run) begin
          @(posedge clk);
          #1;
          if (tog_run) out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Two ops in flight behind a stalled consumer, then flush.
    send(3'd1, 32'h3F800000, 32'h40000000, 32'd1, 1'b0);
    send(3'd0, 32'h3F800000, 32'h3F800000, 32'd1, 1'b0);
    flush = 1'b1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb_q.delete();
    check("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("post_flush_valid", 64'(out_valid), 64'd0);
    end

    // Double precision.
    dsend_chk("d_flt", 3'd1, 64'hBFF0000000000000, 64'h3FF0000000000000, 64'd1, 1'b0);
    dsend_chk("d_cnan", 3'd4, 64'h7FF8000000000000, 64'hFFF8000000000000,
              64'h7FF8000000000000, 1'b0);
    dsend_chk("d_snan", 3'd3, 64'h7FF0000000000001, 64'h3FF0000000000000,
              64'h3FF0000000000000, 1'b1);

    // Reset with two double ops in flight.
    d_out_ready = 1'b0;
    d_in_valid  = 1'b1;
    d_in_op     = 3'd1;
    d_in_a      = 64'h3FF0000000000000;
    d_in_b      = 64'h4000000000000000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    check("d_inflight", 64'(d_out_valid), 64'd1);
    resetn = 1'b0;
    #2;
    check("d_rst_valid", 64'(d_out_valid), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    d_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("d_post_rst_valid", 64'(d_out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
